// File: rtl/nonce_sequencer.sv
// Mining-run controller: walks a nonce range, launches one hash job per nonce,
// and stops on the first hash below target or when the range is exhausted.
module nonce_sequencer #(
  parameter int unsigned NONCE_W = 32,
  parameter int unsigned HASH_W  = 256,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [NONCE_W-1:0] nonce_first,
  input  logic [NONCE_W-1:0] nonce_last,
  input  logic [HASH_W-1:0]  target,
  output logic               core_start,
  output logic [NONCE_W-1:0] core_nonce,
  output logic               core_abort,
  input  logic               core_done,
  input  logic [HASH_W-1:0]  core_hash,
  output logic               busy,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               exhausted,
  output logic               timeout_err,
  output logic [31:0]        hash_count
);

  localparam int unsigned TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CNT_W   = 32;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_CHECK  = 2'd3;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  logic [1:0]         state, state_d;
  logic [NONCE_W-1:0] cur, cur_d;
  logic [NONCE_W-1:0] last_q, last_d;
  logic [HASH_W-1:0]  target_q, target_d;
  logic [HASH_W-1:0]  hash_q, hash_d;
  logic [TIMER_W-1:0] timer, timer_d;

  logic               core_start_d;
  logic [NONCE_W-1:0] core_nonce_d;
  logic               core_abort_d;
  logic               busy_d;
  logic               found_d;
  logic [NONCE_W-1:0] found_nonce_d;
  logic               exhausted_d;
  logic               timeout_err_d;
  logic [CNT_W-1:0]   hash_count_d;

  // Next-state and next-output logic; outputs are computed one edge ahead so
  // that core_start is high exactly during LAUNCH.
  always_comb begin
    state_d       = state;
    cur_d         = cur;
    last_d        = last_q;
    target_d      = target_q;
    hash_d        = hash_q;
    timer_d       = timer;
    core_start_d  = 1'b0;
    core_abort_d  = 1'b0;
    core_nonce_d  = core_nonce;
    found_d       = found;
    found_nonce_d = found_nonce;
    exhausted_d   = exhausted;
    timeout_err_d = timeout_err;
    hash_count_d  = hash_count;

    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          last_d        = nonce_last;
          target_d      = target;
          cur_d         = nonce_first;
          found_d       = 1'b0;
          exhausted_d   = 1'b0;
          timeout_err_d = 1'b0;
          hash_count_d  = '0;
          core_start_d  = 1'b1;
          core_nonce_d  = nonce_first;
          state_d       = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (stop) begin
          core_abort_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop) begin
          core_abort_d = 1'b1;
          state_d      = S_IDLE;
        end else if (core_done) begin
          hash_d  = core_hash;
          state_d = S_CHECK;
        end else if (timer == TIMER_LAST) begin
          timeout_err_d = 1'b1;
          core_abort_d  = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer + TIMER_W'(1);
        end
      end
      default: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          if (hash_count != '1) begin
            hash_count_d = hash_count + CNT_W'(1);
          end
          if (hash_q < target_q) begin
            found_d       = 1'b1;
            found_nonce_d = cur;
            state_d       = S_IDLE;
          end else if (cur == last_q) begin
            exhausted_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            cur_d        = cur + NONCE_W'(1);
            core_nonce_d = cur + NONCE_W'(1);
            core_start_d = 1'b1;
            state_d      = S_LAUNCH;
          end
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cur         <= '0;
      last_q      <= '0;
      target_q    <= '0;
      hash_q      <= '0;
      timer       <= '0;
      core_start  <= 1'b0;
      core_nonce  <= '0;
      core_abort  <= 1'b0;
      busy        <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
      exhausted   <= 1'b0;
      timeout_err <= 1'b0;
      hash_count  <= '0;
    end else begin
      state       <= state_d;
      cur         <= cur_d;
      last_q      <= last_d;
      target_q    <= target_d;
      hash_q      <= hash_d;
      timer       <= timer_d;
      core_start  <= core_start_d;
      core_nonce  <= core_nonce_d;
      core_abort  <= core_abort_d;
      busy        <= busy_d;
      found       <= found_d;
      found_nonce <= found_nonce_d;
      exhausted   <= exhausted_d;
      timeout_err <= timeout_err_d;
      hash_count  <= hash_count_d;
    end
  end

endmodule

// File: tb/tb_nonce_sequencer.sv
// Directed bench for nonce_sequencer: table of full runs against a model hash
// core, plus hand sequences for timeout, stop-with-done and mid-run reset.
module tb_nonce_sequencer;

  localparam logic [255:0] T_ALL = {256{1'b1}};
  localparam logic [255:0] T_FF  = {8'h00, {248{1'b1}}};

  logic         clk, rst, start, stop;
  logic [31:0]  nonce_first, nonce_last;
  logic [255:0] target;
  logic         core_start, core_abort, core_done;
  logic [31:0]  core_nonce;
  logic [255:0] core_hash;
  logic         busy, found, exhausted, timeout_err;
  logic [31:0]  found_nonce, hash_count;

  logic         auto_done, man_done;
  logic [255:0] auto_hash, man_hash;
  assign core_done = auto_done | man_done;
  assign core_hash = man_done ? man_hash : auto_hash;

  int checks, failures;

  // Model-core controls, written only by the main sequence.
  logic        resp_en, hit_en;
  logic [31:0] hit_n;
  int          lat;

  nonce_sequencer #(.NONCE_W(32), .HASH_W(256), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .nonce_first(nonce_first), .nonce_last(nonce_last), .target(target),
    .core_start(core_start), .core_nonce(core_nonce), .core_abort(core_abort),
    .core_done(core_done), .core_hash(core_hash),
    .busy(busy), .found(found), .found_nonce(found_nonce),
    .exhausted(exhausted), .timeout_err(timeout_err), .hash_count(hash_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model hash core: answers lat cycles into WAIT; hash 0 on the hit nonce, else all-ones.
  initial begin
    int pend;
    logic [31:0] jn;
    auto_done = 1'b0;
    auto_hash = '0;
    pend = -1;
    jn = '0;
    forever begin
      @(negedge clk);
      auto_done = 1'b0;
      if (pend == 0) begin
        auto_done = 1'b1;
        auto_hash = (hit_en && jn == hit_n) ? '0 : T_ALL;
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
      if (core_start && resp_en) begin
        pend = lat;
        jn = core_nonce;
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]  first;
    logic [31:0]  last;
    logic [31:0]  hit;
    logic         hit_en;
    logic [255:0] tgt;
    int           lat;
    logic         e_found;
    logic [31:0]  e_fn;
    logic         e_exh;
    logic [31:0]  e_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    int pulses, aborts;
    bit done;
    logic [31:0] expn;
    hit_en = v.hit_en;
    hit_n = v.hit;
    lat = v.lat;
    nonce_first = v.first;
    nonce_last = v.last;
    target = v.tgt;
    start = 1'b1;
    pulses = 0;
    aborts = 0;
    done = 1'b0;
    expn = v.first;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (core_start) begin
        chk("seq_nonce", 256'(core_nonce), 256'(expn));
        expn = expn + 32'd1;
        pulses++;
      end
      if (core_abort) aborts++;
      if (!busy) done = 1'b1;
    end
    chk("run_bound", 256'(done), 256'(1));
    chk("found", 256'(found), 256'(v.e_found));
    if (v.e_found) chk("found_nonce", 256'(found_nonce), 256'(v.e_fn));
    chk("exhausted", 256'(exhausted), 256'(v.e_exh));
    chk("timeout_err", 256'(timeout_err), 256'(0));
    chk("hash_count", 256'(hash_count), 256'(v.e_cnt));
    chk("start_pulses", 256'(pulses), 256'(v.e_cnt));
    chk("abort_pulses", 256'(aborts), 256'(0));
  endtask

  // Returns at the negedge during which core_start is high.
  task automatic wait_start();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (core_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wait_start", 256'(ok), 256'(1));
  endtask

  task automatic manual_job(input bit with_stop);
    wait_start();
    @(negedge clk);
    man_done = 1'b1;
    man_hash = T_ALL;
    stop = with_stop;
    @(negedge clk);
    man_done = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    int ab;
    checks = 0;
    failures = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    nonce_first = '0; nonce_last = '0; target = '0;
    man_done = 1'b0; man_hash = '0;
    resp_en = 1'b1; hit_en = 1'b0; hit_n = '0; lat = 0;

    vecs[0] = '{32'd5, 32'd9, 32'd5, 1'b1, T_ALL, 0, 1'b1, 32'd5, 1'b0, 32'd1};
    vecs[1] = '{32'd0, 32'd3, 32'd0, 1'b0, T_FF, 2, 1'b0, 32'd0, 1'b1, 32'd4};
    vecs[2] = '{32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0, T_FF, 1, 1'b0, 32'd0, 1'b1, 32'd4};
    vecs[3] = '{32'd100, 32'd110, 32'd103, 1'b1, T_ALL, 3, 1'b1, 32'd103, 1'b0, 32'd4};
    vecs[4] = '{32'd7, 32'd7, 32'd0, 1'b0, T_ALL, 0, 1'b0, 32'd0, 1'b1, 32'd1};
    vecs[5] = '{32'd7, 32'd7, 32'd7, 1'b1, T_FF, 5, 1'b1, 32'd7, 1'b0, 32'd1};
    vecs[6] = '{32'd3, 32'd4, 32'd3, 1'b1, 256'd0, 1, 1'b0, 32'd0, 1'b1, 32'd2};
    vecs[7] = '{32'd10, 32'd12, 32'd11, 1'b1, 256'd1, 0, 1'b1, 32'd11, 1'b0, 32'd2};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_core_start", 256'(core_start), 256'(0));
    chk("rst_core_nonce", 256'(core_nonce), 256'(0));
    chk("rst_found_nonce", 256'(found_nonce), 256'(0));
    chk("rst_hash_count", 256'(hash_count), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      @(negedge clk);
    end

    // Timeout with a silent core, then a late result that must be ignored
    resp_en = 1'b0;
    nonce_first = 32'd0; nonce_last = 32'd5; target = T_ALL;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("to_core_start", 256'(core_start), 256'(1));
    ab = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (core_abort) begin
        ab = c;
        break;
      end
    end
    chk("to_abort_cycle", 256'(ab), 256'(1 + 16));
    chk("to_flag", 256'(timeout_err), 256'(1));
    chk("to_busy", 256'(busy), 256'(0));
    @(negedge clk);
    chk("to_abort_single", 256'(core_abort), 256'(0));
    man_done = 1'b1;
    man_hash = '0;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    chk("late_found", 256'(found), 256'(0));
    chk("late_to_flag", 256'(timeout_err), 256'(1));
    chk("late_count", 256'(hash_count), 256'(0));
    chk("late_busy", 256'(busy), 256'(0));

    // stop coincident with core_done on job 3
    nonce_first = 32'd0; nonce_last = 32'd9; target = T_FF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    manual_job(1'b0);
    manual_job(1'b0);
    manual_job(1'b1);
    chk("stop_busy", 256'(busy), 256'(0));
    chk("stop_abort", 256'(core_abort), 256'(1));
    chk("stop_found", 256'(found), 256'(0));
    chk("stop_exh", 256'(exhausted), 256'(0));
    chk("stop_to", 256'(timeout_err), 256'(0));
    chk("stop_count", 256'(hash_count), 256'(2));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_count", 256'(hash_count), 256'(0));
    chk("restart_busy", 256'(busy), 256'(1));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_launch_abort", 256'(core_abort), 256'(1));
    @(negedge clk);

    // Reset while waiting on the core
    nonce_first = 32'h55; nonce_last = 32'h60; target = T_FF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 256'(busy), 256'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_core_nonce", 256'(core_nonce), 256'(0));
    chk("mid_rst_found_nonce", 256'(found_nonce), 256'(0));
    chk("mid_rst_abort", 256'(core_abort), 256'(0));
    chk("mid_rst_flags", 256'({found, exhausted, timeout_err, core_start}), 256'(0));
    chk("mid_rst_count", 256'(hash_count), 256'(0));
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_busy", 256'(busy), 256'(1));
    chk("post_rst_core_start", 256'(core_start), 256'(1));
    chk("post_rst_core_nonce", 256'(core_nonce), 256'(32'h55));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("post_rst_stop_busy", 256'(busy), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
